// File: rtl/mux_nto1_rr.sv
// N-channel registered mux with round-robin grant and valid/ready on every port.
// Optional FORCE_SEL_EN macro adds force_en/force_ch to pin selection to one channel.
module mux_nto1_rr #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef FORCE_SEL_EN
  ,
  input  logic                  force_en,
  input  logic [SELW-1:0]       force_ch
`endif
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  gnt;
  logic [SELW-1:0]  ptr_nxt;
  logic [WIDTH-1:0] sel_data;
  logic             gnt_vld;
  logic             forced;
  logic             can_load;
  logic             take;
  int               idx;

  assign can_load = !out_valid || out_ready;
  // Nothing is granted while reset is asserted, so no producer loses a word.
  assign take     = can_load && gnt_vld && !rst;

  // Scan from ptr upward with wrap; descending loop lets the nearest valid win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    forced  = 1'b0;
    idx     = 0;
    for (int k = NCH-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NCH;
      if (in_valid[idx[SELW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[SELW-1:0];
      end
    end
`ifdef FORCE_SEL_EN
    if (force_en) begin
      forced  = 1'b1;
      gnt     = force_ch;
      gnt_vld = (int'(force_ch) < NCH) && in_valid[force_ch];
    end
`endif
  end

  assign sel_data = in_data[int'(gnt)*WIDTH +: WIDTH];
  assign ptr_nxt  = (gnt == SELW'(NCH-1)) ? '0 : gnt + 1'b1;

  for (genvar i = 0; i < NCH; i++) begin : g_rdy
    assign in_ready[i] = take && (gnt == SELW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (can_load) begin
      if (gnt_vld) begin
        out_data  <= sel_data;
        out_ch    <= gnt;
        out_valid <= 1'b1;
        if (!forced) ptr <= ptr_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed table-driven bench for mux_nto1_rr (WIDTH=4, NCH=4).
module tb_mux_nto1_rr;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef FORCE_SEL_EN
  logic        force_en;
  logic [1:0]  force_ch;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mux_nto1_rr #(.WIDTH(4), .NCH(4), .SELW(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef FORCE_SEL_EN
    , .force_en(force_en), .force_ch(force_ch)
`endif
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] data;
    logic        ordy;
    logic [3:0]  xrdy;
    logic        xv;
    logic [3:0]  xd;
    logic [1:0]  xch;
    logic [1:0]  xptr;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
  endtask

  initial begin
    // rst, valid, data, out_ready | in_ready, out_valid, out_data, out_ch, ptr (after edge)
    tbl[0]  = '{1'b1, 4'hf, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0, 2'd0};
    tbl[1]  = '{1'b1, 4'hf, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0, 2'd0};
    tbl[2]  = '{1'b0, 4'hf, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0, 2'd1};
    tbl[3]  = '{1'b0, 4'hf, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1, 2'd2};
    tbl[4]  = '{1'b0, 4'hf, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2, 2'd3};
    tbl[5]  = '{1'b0, 4'hf, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3, 2'd0};
    tbl[6]  = '{1'b0, 4'hf, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0, 2'd1};
    tbl[7]  = '{1'b0, 4'h2, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1, 2'd2};
    // sparse with wrap: ptr=2, only ch3/ch1 valid
    tbl[8]  = '{1'b0, 4'ha, 16'h9050, 1'b1, 4'b1000, 1'b1, 4'h9, 2'd3, 2'd0};
    tbl[9]  = '{1'b0, 4'ha, 16'h9050, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1, 2'd2};
    tbl[10] = '{1'b0, 4'h0, 16'h9050, 1'b1, 4'b0000, 1'b0, 4'h5, 2'd1, 2'd2};
    // backpressure: three stalled cycles with ch2 waiting
    tbl[11] = '{1'b0, 4'h4, 16'h0a00, 1'b1, 4'b0100, 1'b1, 4'ha, 2'd2, 2'd3};
    tbl[12] = '{1'b0, 4'h4, 16'h0b00, 1'b0, 4'b0000, 1'b1, 4'ha, 2'd2, 2'd3};
    tbl[13] = '{1'b0, 4'h4, 16'h0b00, 1'b0, 4'b0000, 1'b1, 4'ha, 2'd2, 2'd3};
    tbl[14] = '{1'b0, 4'h4, 16'h0b00, 1'b0, 4'b0000, 1'b1, 4'ha, 2'd2, 2'd3};
    tbl[15] = '{1'b0, 4'h4, 16'h0b00, 1'b1, 4'b0100, 1'b1, 4'hb, 2'd2, 2'd3};
    tbl[16] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'b0000, 1'b1, 4'hb, 2'd2, 2'd3};
    // reset mid-stream with word 7 pending
    tbl[17] = '{1'b0, 4'h1, 16'h0007, 1'b1, 4'b0001, 1'b1, 4'h7, 2'd0, 2'd1};
    tbl[18] = '{1'b1, 4'h1, 16'h0007, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0, 2'd0};
    tbl[19] = '{1'b0, 4'hf, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0, 2'd1};

    rst = 1'b1; in_data = '0; in_valid = '0; out_ready = 1'b0;
`ifdef FORCE_SEL_EN
    force_en = 1'b0; force_ch = 2'd0;
`endif
    @(posedge clk); #1;

    for (int r = 0; r < 20; r++) begin
      rst = tbl[r].rst; in_valid = tbl[r].valid; in_data = tbl[r].data; out_ready = tbl[r].ordy;
      #1;
      chk("in_ready", r, 32'(in_ready), 32'(tbl[r].xrdy));
      @(posedge clk); #1;
      chk("out_valid", r, 32'(out_valid), 32'(tbl[r].xv));
      chk("out_data",  r, 32'(out_data),  32'(tbl[r].xd));
      chk("out_ch",    r, 32'(out_ch),    32'(tbl[r].xch));
      chk("ptr",       r, 32'(dut.ptr),   32'(tbl[r].xptr));
    end

`ifdef FORCE_SEL_EN
    // forced ch2 with everyone valid: ch2 granted every cycle, ptr stays at 1
    force_en = 1'b1; force_ch = 2'd2; in_valid = 4'hf; in_data = 16'h4321; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("force_rdy", 100+c, 32'(in_ready), 32'h4);
      @(posedge clk); #1;
      chk("force_ch",  100+c, 32'(out_ch),   32'd2);
      chk("force_dat", 100+c, 32'(out_data), 32'd3);
      chk("force_ptr", 100+c, 32'(dut.ptr),  32'd1);
    end
    in_valid = 4'b1011;
    #1;
    chk("force_idle_rdy", 110, 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("force_idle_v",   110, 32'(out_valid), 32'd0);
    chk("force_idle_ptr", 110, 32'(dut.ptr),   32'd1);
    force_en = 1'b0;
`endif

    // hand sequence: stall with a consumer return in the same cycle as a new grant
    in_valid = 4'h8; in_data = 16'hc000; out_ready = 1'b0;
    #1;
    chk("stall_rdy", 200, 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("stall_dat", 200, 32'(out_data), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("swap_rdy", 201, 32'(in_ready), 32'h8);
    @(posedge clk); #1;
    chk("swap_dat", 201, 32'(out_data), 32'hc);
    chk("swap_ch",  201, 32'(out_ch),   32'd3);
    chk("swap_ptr", 201, 32'(dut.ptr),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
